// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Handles byte/half/word lanes, sign/zero extension, alignment checks and RMW for SB/SH.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t                   state, state_next;
    logic                     we_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [DATA_WIDTH-1:0]    word_q;

    logic                     accept;
    logic                     req_bad;
    logic [4:0]               lane_shift;
    logic [DATA_WIDTH-1:0]    rd_shifted;
    logic [DATA_WIDTH-1:0]    load_ext;
    logic [DATA_WIDTH-1:0]    lane_mask;
    logic [DATA_WIDTH-1:0]    merged;
    logic                     unused_addr_bits;

    // Upper address bits alias onto the small memory and are intentionally dropped.
    assign unused_addr_bits = ^req_addr[31:ADDRESS_WIDTH+2];

    assign accept = req_valid & req_ready;

    // Illegal funct3 and misalignment both collapse into a single error response.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        req_bad = 1'b1;
        case (req_funct3)
            F3_B:    req_bad = 1'b0;
            F3_H:    req_bad = req_addr[0];
            F3_W:    req_bad = (req_addr[1:0] != 2'b00);
            F3_BU:   req_bad = req_we;
            F3_HU:   req_bad = req_we | req_addr[0];
            default: req_bad = 1'b1;
        endcase
    end

    assign lane_shift = {addr_q[1:0], 3'b000};
    assign rd_shifted = mem_rd >> lane_shift;

    always_comb begin
        load_ext = mem_rd;
        case (funct3_q)
            F3_B:    load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_H:    load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_BU:   load_ext = {24'h0, rd_shifted[7:0]};
            F3_HU:   load_ext = {16'h0, rd_shifted[15:0]};
            default: load_ext = mem_rd;
        endcase
    end

    assign lane_mask = ((funct3_q == F3_H) ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
    assign merged    = (word_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            word_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_next;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDRESS_WIDTH+1:0];
                wdata_q  <= req_wdata;
                err_q    <= req_bad;
            end
            if (state == ACCESS && !we_q) rdata_q <= load_ext;
            if (state == ACCESS && we_q)  word_q  <= mem_rd;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_bad ? RESP : ACCESS;
            ACCESS:  state_next = (we_q && funct3_q != F3_W) ? MERGE : RESP;
            MERGE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are gated by rst so a write in flight drops the instant reset rises.
    always_comb begin
        req_ready  = (state == IDLE) && !rst;
        resp_valid = (state == RESP) && !rst;
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !we_q) ? rdata_q : '0;
        mem_a      = (state == IDLE) ? '0 : addr_q[ADDRESS_WIDTH+1:2];
        mem_we     = !rst && ((state == ACCESS && we_q && funct3_q == F3_W) || state == MERGE);
        mem_wd     = '0;
        if (mem_we) mem_wd = (state == MERGE) ? merged : wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hand-written back-to-back and
// reset-during-RMW sequences, against a behavioural 32-word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [4:0]  mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:31] = '{default: 32'h0};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;
    assign mem_rd = mem[mem_a];

    load_store_unit #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request and records response latency and any memory write seen.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int wr_cycle,
                           output logic [4:0] wr_a, output logic [31:0] wr_wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wr_cycle = 0; wr_a = '0; wr_wd = '0; rdata = '0; err = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) begin
                wr_cycle = c;
                wr_a     = mem_a;
                wr_wd    = mem_wd;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    vec_t        vecs [19];
    logic [31:0] rdata, wr_wd;
    logic        err;
    logic [4:0]  wr_a;
    int          lat, wr_cycle, accepts, resp_cyc;

    initial begin
        vecs = '{
            '{1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1, 32'hDEAD_BEEF},
            '{1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0},
            '{1'b1, 3'b000, 32'h0000_0009, 32'hFFFF_FF7F, 32'h0000_0000, 1'b0, 3, 2, 32'hDEAD_7FEF},
            '{1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hDEAD_7FEF, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b000, 32'h0000_0009, 32'h0,         32'h0000_007F, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b000, 32'h0000_000B, 32'h0,         32'hFFFF_FFDE, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b100, 32'h0000_000B, 32'h0,         32'h0000_00DE, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b101, 32'h0000_000A, 32'h0,         32'h0000_DEAD, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b001, 32'h0000_000A, 32'h0,         32'hFFFF_DEAD, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b000, 32'h0000_0008, 32'h0,         32'hFFFF_FFEF, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b001, 32'h0000_0009, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 32'h0},
            '{1'b1, 3'b010, 32'h0000_0006, 32'h1234_5678, 32'h0000_0000, 1'b1, 1, 0, 32'h0},
            '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 32'h0},
            '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 1'b1, 1, 0, 32'h0},
            '{1'b1, 3'b001, 32'h0000_002A, 32'h1234_BEEF, 32'h0000_0000, 1'b0, 3, 2, 32'hBEEF_0000},
            '{1'b0, 3'b010, 32'h0000_0028, 32'h0,         32'hBEEF_0000, 1'b0, 2, 0, 32'h0},
            '{1'b0, 3'b101, 32'hFFFF_FF88, 32'h0,         32'h0000_7FEF, 1'b0, 2, 0, 32'h0},
            '{1'b1, 3'b010, 32'h0000_0010, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0, 2, 1, 32'hAAAA_AAAA},
            '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hAAAA_AAAA, 1'b0, 2, 0, 32'h0}
        };

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset mem_a", 32'(mem_a), 32'd0);
        rst = 1'b0;
        #1 check("post-reset req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 19; i++) begin
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    rdata, err, lat, wr_cycle, wr_a, wr_wd);
            check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d write cycle", i), wr_cycle, vecs[i].exp_wr);
            check($sformatf("v%0d write data", i), wr_wd, vecs[i].exp_wd);
            if (vecs[i].exp_wr != 0)
                check($sformatf("v%0d write addr", i), 32'(wr_a), 32'(vecs[i].addr[6:2]));
        end

        // Back-to-back: req_valid held through an SH, then retargeted to an LW.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0000_0030; req_wdata = 32'h0000_5555;
        accepts = req_ready ? 1 : 0;
        resp_cyc = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (req_ready) accepts++;
            if (resp_valid) resp_cyc = c;
        end
        check("b2b single accept", accepts, 1);
        check("b2b SH resp cycle", resp_cyc, 3);
        req_we = 1'b0; req_funct3 = 3'b010; req_wdata = '0;
        @(negedge clk);
        check("b2b ready after resp", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                rdata = resp_rdata;
                break;
            end
        end
        check("b2b LW latency", lat, 2);
        check("b2b LW rdata", rdata, 32'h0000_5555);

        // Reset during MERGE of SH 0x1234 @0x10 must leave the word untouched.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0000_0010; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw access no write", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("rmw merge write pending", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("mid-rst mem_we", 32'(mem_we), 32'd0);
        check("mid-rst req_ready", 32'(req_ready), 32'd0);
        check("mid-rst mem_a", 32'(mem_a), 32'd0);
        resp_cyc = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) resp_cyc++;
        end
        check("mid-rst no response", resp_cyc, 0);
        rst = 1'b0;
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, rdata, err, lat, wr_cycle, wr_a, wr_wd);
        check("post-rst LW rdata", rdata, 32'hAAAA_AAAA);
        check("post-rst LW err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
